// File: rtl/i2c_target.sv
// ============================================================================
// Module  : i2c_target
// Brief   : I2C target endpoint exposing a byte-addressed register file.
//           SCL/SDA are oversampled on clk; SDA is driven open-drain via an
//           output enable. A combinational debug port reads any register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         PTR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] dbg_addr,
  output logic [7:0]       dbg_data,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam int DEPTH = 2 ** PTR_W;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_WDATA     = 4'd4;
  localparam logic [3:0] S_WACK      = 4'd5;
  localparam logic [3:0] S_RDATA     = 4'd6;
  localparam logic [3:0] S_RDATA_ACK = 4'd7;
  localparam logic [3:0] S_IGNORE    = 4'd8;

  // bit counter value meaning "next falling edge loads and drives bit 7"
  localparam logic [3:0] CNT_PRIME   = 4'd8;

  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;

  logic [3:0]       state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             ackd_q, ackd_d;
  logic             rw_q, rw_d;
  logic [7:0]       regs_q [DEPTH];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       last_bit;
  logic       wr_en;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign last_bit  = (bitcnt_q == 4'd7);
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign wr_en     = (state_q == S_WDATA) && scl_rise && last_bit;

  // Two-flop synchronizers plus one history flop per pin; idle bus reads high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; STOP and START override every state
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && last_bit) begin
            state_d = (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall && ackd_q) begin
            state_d = rw_q ? S_RDATA : S_PTR;
          end
        end
        S_PTR, S_WDATA: begin
          if (scl_rise && last_bit) begin
            state_d = S_WACK;
          end
        end
        S_WACK: begin
          if (scl_fall && ackd_q) begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_fall && last_bit) begin
            state_d = S_RDATA_ACK;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            state_d = sda_s2_q ? S_IGNORE : S_RDATA;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Datapath next values: shifter, bit counter, pointer, SDA enable, busy
  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    ackd_d   = ackd_q;
    rw_d     = rw_q;
    if (stop_det) begin
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      ackd_d   = 1'b0;
      bitcnt_d = 4'd0;
    end else if (start_det) begin
      oe_d     = 1'b0;
      ackd_d   = 1'b0;
      bitcnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (last_bit) begin
              bitcnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                rw_d = sda_s2_q;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                end
              end
              if (state_q == S_PTR) begin
                ptr_d = rx_byte[PTR_W-1:0];
              end
              if (state_q == S_WDATA) begin
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK, S_WACK: begin
          // first fall pulls SDA for the ACK, second fall ends the ACK slot
          if (scl_fall) begin
            if (!ackd_q) begin
              oe_d   = 1'b1;
              ackd_d = 1'b1;
            end else begin
              ackd_d   = 1'b0;
              bitcnt_d = 4'd0;
              if ((state_q == S_ADDR_ACK) && rw_q) begin
                shift_d = regs_q[ptr_q];
                oe_d    = ~regs_q[ptr_q][7];
              end else begin
                oe_d = 1'b0;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == CNT_PRIME) begin
              shift_d  = regs_q[ptr_q];
              oe_d     = ~regs_q[ptr_q][7];
              bitcnt_d = 4'd0;
            end else if (last_bit) begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              oe_d     = ~shift_q[6];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise && !sda_s2_q) begin
            ptr_d    = ptr_q + 1'b1;
            bitcnt_d = CNT_PRIME;
          end
        end
        default: begin
          oe_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_q <= 4'd0;
      shift_q  <= 8'h00;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      ackd_q   <= 1'b0;
      rw_q     <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      ackd_q   <= ackd_d;
      rw_q     <= rw_d;
    end
  end

  // Register file; a write lands on the edge where the 8th data bit is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  // Outputs; a detected START releases SDA without waiting for the register
  always_comb begin
    sda_oe   = oe_q & ~start_det;
    wr_valid = wr_en;
    wr_addr  = ptr_q;
    wr_data  = rx_byte;
    busy     = busy_q;
    dbg_data = regs_q[dbg_addr];
  end

endmodule

`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint: the responder for the team's I2C bus master.
- Exposes a byte-addressed register file to an external I2C controller, so the master/HDMI configuration path can be looped back and checked on-chip.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain through an output-enable only.
- Sits beside the HDMI/I2C logic in the chip interface; a debug read port feeds the seven-segment displays.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address matched against the first byte after START.
- PTR_W, 4, register pointer width; register file depth is 2**PTR_W bytes.

Ports:
- clk  input  1  system clock; must be at least 10x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL pin level.
- sda_i  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release. The top level drives SDA = sda_oe ? 0 : Z.
- dbg_addr  input  PTR_W  debug read index.
- dbg_data  output  8  reg[dbg_addr]; combinational.
- wr_valid  output  1  one-cycle pulse on each register write committed over I2C.
- wr_addr  output  PTR_W  index of the committed write; valid while wr_valid=1.
- wr_data  output  8  data of the committed write; valid while wr_valid=1.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset (rst=0, asynchronous):
  - sda_oe=0, wr_valid=0, busy=0, state=IDLE, pointer=0.
  - All registers=8'h00.
  - Synchronizer flops preset to 1 (bus idle).
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer, then a 1-flop history used for edge detection.
  - A pin change is seen 3 clk later.
- Bus events:
  - START/Sr: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Bits are sampled on the SCL rising edge.
  - sda_oe changes only on the detected SCL falling edge.
- START from any state: clear the bit counter, go to ADDR. Sr keeps the pointer.
- STOP from any state: go to IDLE, release sda_oe, clear busy. A partial byte is discarded and no write is committed.
- ADDR: shift 8 bits MSB first.
  - If [7:1]==DEV_ADDR: go to ADDR_ACK and set busy.
  - Otherwise go to IGNORE (sda_oe held 0 until START/STOP).
- ADDR_ACK:
  - Assert sda_oe at the falling edge after bit 8; release at the next falling edge.
  - R/W=0: go to PTR.
  - R/W=1: go to RDATA, loading the shifter with reg[pointer]. Bit 7 is driven at that same falling edge.
- PTR: receive 8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored); ACK; go to WDATA.
- WDATA: receive 8 bits; ACK; then:
  - reg[pointer] <= byte;
  - wr_valid pulses one clk in the cycle the 8th rising edge is detected;
  - pointer increments.
  - Repeat until START/STOP.
- RDATA:
  - Drive sda_oe = ~bit for 8 bits, each updated on a falling edge.
  - After the 8th falling edge, release and go to RDATA_ACK.
- RDATA_ACK: sample the master's bit on the rising edge.
  - ACK (0): pointer++, load the next byte, go to RDATA.
  - NACK (1): go to IGNORE until STOP/Sr.
- Pointer wraps from 2**PTR_W-1 to 0 silently, on both write and read.
- Simultaneous debug read and I2C write to the same index: dbg_data shows the old value until the clock edge that commits the write.
- START while the target is driving SDA: sda_oe is released in the same cycle the START is detected.

Test Plan:
- Write burst: START, 8'h72, ptr 8'h05, 8'hA5, 8'h3C, STOP.
  - Four ACKs.
  - wr_valid pulses twice: (5,A5) then (6,3C).
  - dbg_addr=5 gives A5; dbg_addr=6 gives 3C.
  - busy falls after STOP.
- Combined read: START 8'h72 ptr 8'h05, Sr, 8'h73, master ACK then NACK, STOP.
  - SDA carries A5 then 3C.
  - sda_oe=0 after the NACK.
  - No wr_valid pulse.
- Address mismatch: START, 8'hA0, data 8'hFF, STOP.
  - sda_oe never asserts, busy stays 0, no register changes.
- Wrap: write ptr 8'h0F with bytes 11, 22.
  - reg[15]=11, reg[0]=22.
  - A read from ptr 15 returns 11 then 22.
- Abort: STOP after 5 data bits.
  - No wr_valid; target register unchanged.
  - The next full transaction succeeds.
- Reset mid-read: assert rst while sda_oe=1.
  - sda_oe=0 immediately, without waiting for a clock edge.
  - All registers read 00 after release.
